// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: row-scanned keypad with per-key debounce and an event FIFO
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int REL_EN     = 1,
    localparam int RW = $clog2(ROWS),
    localparam int CW = $clog2(COLS),
    localparam int KW = 1 + RW + CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [COLS-1:0]      col_in,
    output logic [ROWS-1:0]      row,
    output logic                 key_valid,
    input  logic                 key_ready,
    output logic [KW-1:0]        key_code,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 overflow,
    input  logic                 ovf_clr
);
    localparam int N  = ROWS * COLS;
    localparam int NW = $clog2(N);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DW-1:0] dcnt;
    logic [RW-1:0] r, sr;
    logic [CW-1:0] cp;
    logic          busy;
    logic [COLS-1:0] s;
    logic [3:0]    cnt [N];
    logic [KW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   fcnt;
    logic          last, cur, diff, fire, push, pop, full, wr, drop;
    logic [NW-1:0] kidx;
    logic [KW-1:0] code;

    assign last = dcnt == DW'(SCAN_DIV - 1);

    // Row scanner: dwell SCAN_DIV clocks per row, drive the current row low
    always_ff @(posedge clk) begin
        if (rst) begin
            row  <= '1;
            r    <= '0;
            dcnt <= '0;
        end else begin
            row <= ~(ROWS'(1) << r);
            if (last) begin
                dcnt <= '0;
                r    <= (r == RW'(ROWS - 1)) ? '0 : r + RW'(1);
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

    // Latch the columns at the end of a row's dwell, then walk one column per clock
    always_ff @(posedge clk) begin
        if (rst) begin
            s    <= '0;
            sr   <= '0;
            cp   <= '0;
            busy <= 1'b0;
        end else if (last) begin
            s    <= ~col_in;
            sr   <= r;
            cp   <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            cp   <= cp + CW'(1);
            busy <= cp != CW'(COLS - 1);
        end
    end

    // Evaluate the key under the column pointer and decide whether it toggles
    always_comb begin
        kidx = NW'(sr * COLS + cp);
        cur  = key_state[kidx];
        diff = busy && (s[cp] != cur);
        fire = diff && (cnt[kidx] == 4'(DEBOUNCE - 1));
        push = fire && (!cur || REL_EN != 0);
        code = {~cur, sr, cp};
    end

    // Debounce counters and the debounced key map
    always_ff @(posedge clk) begin
        if (rst) begin
            key_state <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (busy) begin
            cnt[kidx] <= (diff && !fire) ? cnt[kidx] + 4'd1 : 4'd0;
            if (fire) key_state[kidx] <= ~cur;
        end
    end

    assign pop       = key_valid && key_ready;
    assign full      = fcnt == (AW+1)'(FIFO_DEPTH);
    assign wr        = push && (!full || pop);
    assign drop      = push && full && !pop;
    assign key_valid = fcnt != '0;
    assign key_code  = key_valid ? mem[rp] : '0;

    // FIFO pointers, occupancy and the sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            fcnt     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fcnt     <= fcnt + (AW+1)'(wr) - (AW+1)'(pop);
            overflow <= drop || (overflow && !ovf_clr);
        end
    end

    // FIFO storage; contents are meaningless while the occupancy says empty
    always_ff @(posedge clk) begin
        if (wr) mem[wp] <= code;
    end
endmodule

// File: doc/keypad_scan_fifo.md
KEYPAD_SCAN_FIFO -- requirements
Module: keypad_scan_fifo

Interface
REQ-001 SHALL have parameter ROWS, default 4, number of scanned rows (>=2).
REQ-002 SHALL have parameter COLS, default 4, number of sensed columns (>=2).
REQ-003 SHALL have parameter SCAN_DIV, default 1000, clocks each row is driven; legal range >= COLS+1.
REQ-004 SHALL have parameter DEBOUNCE, default 3, consecutive equal samples needed to change a key state (1..15).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, event buffer entries (power of 2, >=2).
REQ-006 SHALL have parameter REL_EN, default 1, 1 = report releases as well as presses.
REQ-007 Widths: RW = clog2(ROWS), CW = clog2(COLS), KW = 1+RW+CW.
REQ-008 clk  in  1  sole clock; all logic on the rising edge.
REQ-009 rst  in  1  reset, synchronous and active-high.
REQ-010 col_in  in  COLS  column sense, active-low (0 = key closed on driven row).
REQ-011 row  out  ROWS  row drive, active-low, at most one bit low.
REQ-012 key_valid  out  1  FIFO head valid.
REQ-013 key_ready  in  1  consumer accepts head.
REQ-014 key_code  out  KW  head event {press(1)/release(0), row idx, col idx}.
REQ-015 key_state  out  ROWS*COLS  debounced state, bit r*COLS+c, 1 = pressed.
REQ-016 overflow  out  1  sticky: an event was dropped.
REQ-017 ovf_clr  in  1  clears overflow.

Function
REQ-018 Scanner SHALL hold row index r for SCAN_DIV clocks, then r <= r+1, wrapping ROWS-1 -> 0; row = ~(1<<r), registered.
REQ-019 On the last dwell clock of row r, col_in SHALL be latched as raw sample s = ~col_in, tagged with r.
REQ-020 During the next COLS clocks, column pointer c = 0..COLS-1 SHALL evaluate one key (r,c) per clock, ascending.
REQ-021 Per key: if s[c] != key_state bit, debounce count += 1; else count <= 0; when count reaches DEBOUNCE, state bit SHALL toggle, count <= 0.
REQ-022 Each key is sampled once per frame (ROWS*SCAN_DIV clocks); a change needs DEBOUNCE consecutive disagreeing frames; any agreeing frame restarts counting.
REQ-023 Press toggle SHALL push {1,r,c} in the same clock it is evaluated; release toggle pushes {0,r,c} only if REL_EN = 1.
REQ-024 Multiple simultaneous keys are independent (N-key); same-row events leave in ascending column order, rows in scan order.
REQ-025 FIFO: key_valid = not empty; pop on key_valid & key_ready; key_code = head, stable while key_valid & !key_ready.
REQ-026 Push when full with no pop SHALL drop the event and set overflow; key_state still updates.
REQ-027 Push and pop in the same clock when full SHALL both complete, no overflow.
REQ-028 Push into empty FIFO: key_valid = 1 the next clock (1-clock latency).
REQ-029 ovf_clr clears overflow next clock; simultaneous drop and ovf_clr leaves overflow = 1.

Reset
REQ-030 While rst = 1 (sync): row = all ones, r = 0, dwell count 0, column pointer idle, debounce counts 0, key_state = 0, FIFO empty, key_valid = 0, key_code = 0, overflow = 0.
REQ-031 First clock after rst falls SHALL drive row 0 low (row = ~1).
REQ-032 Reset mid-operation SHALL discard buffered events and held keys without emitting release events.

Verification (ROWS=COLS=4, SCAN_DIV=8, DEBOUNCE=3, FIFO_DEPTH=4 unless stated)
REQ-033 Reset 5 clocks -> row=4'hF, key_valid=0, key_state=0, overflow=0; next clock row=4'hE, then 4'hD after 8 clocks.
REQ-034 Hold key (1,1) closed (col_in[1]=0 when row=4'hD) -> after 3rd sampled frame key_code=5'h15, key_valid=1, key_state[5]=1; one event only.
REQ-035 Key (1,1) closed for 2 frames then open -> no event, key_state[5]=0.
REQ-036 Keys (1,1) and (1,2) closed together -> events 5'h15 then 5'h16, consecutive clocks.
REQ-037 key_ready=0, five press events -> four buffered (first four in order), overflow=1; ovf_clr pulse -> overflow=0; draining yields 4 pops then key_valid=0.
REQ-038 Release of held (1,1): REL_EN=1 -> 5'h05 after 3 frames; REL_EN=0 -> no event, key_state[5] still clears.
